// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decode-side handshake with instruction/operands in, execute-side entry out.
// master drives the upstream inputs and execute ready; slave is the issue register itself.
interface alu_issue_stage_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [31:0]      data1;
  logic [31:0]      data2;
  logic [31:0]      store_data;
  logic [4:0]       dest_reg;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             branch;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;

  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, funct, data1, data2, store_data,
           dest_reg, reg_write, mem_read, mem_write, branch, illegal, issue_count
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, alu_op, funct, data1, data2, store_data,
           dest_reg, reg_write, mem_read, mem_write, branch, illegal, issue_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes opcode into ALUop/funct/controls and selects operand B.
// Latency 1 cycle; accept and consume in one cycle replace the entry with no bubble.
// Backpressure: in_ready = !out_valid | out_ready; a stalled entry holds bit-stable.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  alu_issue_stage_if.slave bus
);

  typedef struct packed {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
  } entry_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  entry_t           dec;
  entry_t           ent_q;
  logic             dec_legal;
  logic             vld_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             consume;
  logic [31:0]      imm_sext;
  logic             unused_fields;

  // rs field and shamt are not needed: rs_data arrives already read.
  assign unused_fields = ^{bus.instr[25:21], bus.instr[10:6]};

  assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};

  always_comb begin
    dec            = '0;
    dec_legal      = 1'b1;
    dec.data1      = bus.rs_data;
    dec.data2      = bus.rt_data;
    dec.store_data = bus.rt_data;
    case (bus.instr[31:26])
      OP_RTYPE: begin
        dec.alu_op    = 2'b10;
        dec.funct     = bus.instr[5:0];
        dec.dest_reg  = bus.instr[15:11];
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.data2     = imm_sext;
        dec.dest_reg  = bus.instr[20:16];
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_SW: begin
        dec.data2     = imm_sext;
        dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = 2'b01;
        dec.branch = 1'b1;
      end
      OP_ADDI: begin
        dec.data2     = imm_sext;
        dec.dest_reg  = bus.instr[20:16];
        dec.reg_write = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign bus.in_ready = ~vld_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign consume      = vld_q & bus.out_ready;

  // Illegal opcodes are accepted (slot freed upstream) but never occupy the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      cnt_q <= '0;
      ent_q <= '0;
    end else begin
      ill_q <= accept & ~dec_legal;
      if (consume && !bus.flush) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (bus.flush) begin
        vld_q <= 1'b0;
        ent_q <= '0;
      end else if (accept && dec_legal) begin
        vld_q <= 1'b1;
        ent_q <= dec;
      end else if (consume) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.alu_op      = ent_q.alu_op;
  assign bus.funct       = ent_q.funct;
  assign bus.data1       = ent_q.data1;
  assign bus.data2       = ent_q.data2;
  assign bus.store_data  = ent_q.store_data;
  assign bus.dest_reg    = ent_q.dest_reg;
  assign bus.reg_write   = ent_q.reg_write;
  assign bus.mem_read    = ent_q.mem_read;
  assign bus.mem_write   = ent_q.mem_write;
  assign bus.branch      = ent_q.branch;
  assign bus.illegal     = ill_q;
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed test-plan cases with literal expectations, then randomized
// traffic compared every cycle against a spec-level model of the issue slot.
module tb_alu_issue_stage;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.CNT_W(CNT_W)) bus ();

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model of the issue slot contents.
  logic        m_init = 1'b0;
  logic        m_vld, m_known, m_ill;
  logic [1:0]  m_op;
  logic [5:0]  m_fn;
  logic [31:0] m_d1, m_d2, m_sd;
  logic [4:0]  m_dst;
  logic        m_rw, m_mr, m_mw, m_br;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_decode(
    input  logic [31:0] ins, rsd, rtd,
    output logic ok, output logic [1:0] op, output logic [5:0] fn,
    output logic [31:0] d2, output logic [4:0] dst,
    output logic rw, output logic mr, output logic mw, output logic br);
    int imm;
    imm = int'($signed(ins[15:0]));
    ok = 1; op = 0; fn = 0; d2 = rtd; dst = 0; rw = 0; mr = 0; mw = 0; br = 0;
    if (ins[31:26] == 6'd0) begin
      op = 2; fn = ins[5:0]; dst = ins[15:11]; rw = 1;
    end else if (ins[31:26] == 6'h23) begin
      d2 = 32'(imm); dst = ins[20:16]; mr = 1; rw = 1;
    end else if (ins[31:26] == 6'h2B) begin
      d2 = 32'(imm); mw = 1;
    end else if (ins[31:26] == 6'h04) begin
      op = 1; br = 1;
    end else if (ins[31:26] == 6'h08) begin
      d2 = 32'(imm); dst = ins[20:16]; rw = 1;
    end else begin
      ok = 0;
    end
    rsd = rsd;
  endfunction

  task automatic compare_all();
    chk("out_valid", bus.out_valid, m_vld);
    chk("illegal", bus.illegal, m_ill);
    chk("issue_count", bus.issue_count, 32'(m_cnt % (1 << CNT_W)));
    chk("reg_write", bus.reg_write, m_rw);
    chk("mem_read", bus.mem_read, m_mr);
    chk("mem_write", bus.mem_write, m_mw);
    chk("branch", bus.branch, m_br);
    if (m_known) begin
      chk("alu_op", bus.alu_op, m_op);
      chk("funct", bus.funct, m_fn);
      chk("data1", bus.data1, m_d1);
      chk("data2", bus.data2, m_d2);
      chk("store_data", bus.store_data, m_sd);
      chk("dest_reg", bus.dest_reg, m_dst);
    end
  endtask

  // One clock: apply inputs at the falling edge, advance the model at the rising edge,
  // compare everything at the next falling edge.
  task automatic cyc(input logic rst, input logic iv, input logic [31:0] ins,
                     input logic [31:0] rsd, input logic [31:0] rtd,
                     input logic fl, input logic ordy);
    logic ok, acc, con, rw, mr, mw, br;
    logic [1:0] op; logic [5:0] fn; logic [31:0] d2; logic [4:0] dst;
    reset = rst; bus.in_valid = iv; bus.instr = ins; bus.rs_data = rsd;
    bus.rt_data = rtd; bus.flush = fl; bus.out_ready = ordy;
    #1;
    if (m_init) chk("in_ready", bus.in_ready, !m_vld || ordy);
    @(posedge clk);
    if (rst) begin
      m_init = 1; m_vld = 0; m_ill = 0; m_cnt = 0; m_known = 1;
      m_op = 0; m_fn = 0; m_d1 = 0; m_d2 = 0; m_sd = 0; m_dst = 0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0;
    end else begin
      acc = iv && (!m_vld || ordy) && !fl;
      con = m_vld && ordy;
      model_decode(ins, rsd, rtd, ok, op, fn, d2, dst, rw, mr, mw, br);
      m_ill = acc && !ok;
      if (con && !fl) m_cnt++;
      if (fl) begin
        m_vld = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_known = 0;
      end else if (acc && ok) begin
        m_vld = 1; m_known = 1; m_op = op; m_fn = fn; m_d1 = rsd; m_d2 = d2;
        m_sd = rtd; m_dst = dst; m_rw = rw; m_mr = mr; m_mw = mw; m_br = br;
      end else if (con) begin
        m_vld = 0;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  logic [5:0] ops [6];
  initial begin
    logic [31:0] ins;
    logic [5:0]  opc;
    int          k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    reset = 1; bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.flush = 0; bus.out_ready = 0;
    @(negedge clk);

    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_in_ready", bus.in_ready, 1'b0 | 1'b1 & ~bus.out_valid);
    chk("rst_out_valid", bus.out_valid, 0);

    // R-type add
    cyc(0, 1, 32'h00851020, 2, 2, 0, 1);
    chk("rt_alu_op", bus.alu_op, 2'b10);
    chk("rt_funct", bus.funct, 6'b100000);
    chk("rt_data1", bus.data1, 2);
    chk("rt_data2", bus.data2, 2);
    chk("rt_dest", bus.dest_reg, 2);
    chk("rt_reg_write", bus.reg_write, 1);
    chk("rt_count0", bus.issue_count, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rt_count1", bus.issue_count, 1);

    // lw with negative offset
    cyc(0, 1, 32'h8C22FFFC, 32'h100, 0, 0, 1);
    chk("lw_alu_op", bus.alu_op, 2'b00);
    chk("lw_data2", bus.data2, 32'hFFFFFFFC);
    chk("lw_dest", bus.dest_reg, 2);
    chk("lw_mem_read", bus.mem_read, 1);
    chk("lw_reg_write", bus.reg_write, 1);

    // beq then sw back to back
    cyc(0, 1, 32'h10850003, 7, 9, 0, 1);
    chk("beq_valid", bus.out_valid, 1);
    chk("beq_alu_op", bus.alu_op, 2'b01);
    chk("beq_branch", bus.branch, 1);
    cyc(0, 1, 32'hAC450008, 3, 32'hDEAD, 0, 1);
    chk("sw_valid", bus.out_valid, 1);
    chk("sw_alu_op", bus.alu_op, 2'b00);
    chk("sw_mem_write", bus.mem_write, 1);
    chk("sw_store_data", bus.store_data, 32'hDEAD);

    // stall three cycles, then release
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h20A3FFFF, 5, 6, 0, 0);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_store_data", bus.store_data, 32'hDEAD);
    end
    cyc(0, 1, 32'h20A3FFFF, 5, 6, 0, 1);
    chk("rel_reg_write", bus.reg_write, 1);
    chk("rel_data2", bus.data2, 32'hFFFFFFFF);
    chk("rel_count", bus.issue_count, 4);

    // flush while stalled with an incoming instruction
    cyc(0, 1, 32'h00851020, 1, 1, 1, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_count", bus.issue_count, 4);

    // illegal opcode, then reset mid-stall
    cyc(0, 1, 32'hFC000000, 0, 0, 0, 1);
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_valid", bus.out_valid, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ill_clear", bus.illegal, 0);
    cyc(0, 1, 32'h00851020, 11, 12, 0, 1);
    cyc(0, 1, 32'h00851020, 11, 12, 0, 0);
    cyc(1, 1, 32'h00851020, 11, 12, 0, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_count", bus.issue_count, 0);
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_data1", bus.data1, 0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      k   = $urandom_range(0, 5);
      opc = (k == 5) ? 6'($urandom) : ops[k];
      ins = {opc, 26'($urandom)};
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, ins, $urandom, $urandom,
          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue register for the pipeline. Takes a fetched 32-bit instruction plus its two register-file read values, decodes the primary opcode into the 2-bit ALUop code and funct field consumed by the ALU control/ALU block, and selects operand B (register or sign-extended immediate). The result is held in one ID/EX register stage with a valid/ready handshake on both sides, plus a flush input for branch redirect. It drives the execute stage directly.

## Interface
- `CNT_W`, default 16: width of the issued-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `instr`  in  32  fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- `rs_data`  in  32  register value for rs.
- `rt_data`  in  32  register value for rt.
- `flush`  in  1  discard held and incoming instruction.
- `out_valid`  out  1  registered outputs carry a valid instruction.
- `out_ready`  in  1  execute stage consumes this cycle.
- `alu_op`  out  2  00 add, 01 subtract (compare), 10 use funct.
- `funct`  out  6  instr[5:0] for R-type, 6'b000000 otherwise.
- `data1`  out  32  ALU operand A (rs_data).
- `data2`  out  32  ALU operand B (rt_data or sign-extended imm).
- `store_data`  out  32  rt_data, used by stores.
- `dest_reg`  out  5  write-back register number.
- `reg_write`, `mem_read`, `mem_write`, `branch`  out  1 each  control bits.
- `illegal`  out  1  one-cycle pulse on accepting an undefined opcode.
- `issue_count`  out  CNT_W  number of instructions handed to execute.

## Operation
- Decode (combinational on `instr`, registered on accept):
  - 000000 R-type: alu_op=10, funct=instr[5:0], data2=rt_data, dest=rd, reg_write=1.
  - 100011 lw: alu_op=00, data2=sext(imm), dest=rt, mem_read=1, reg_write=1.
  - 101011 sw: alu_op=00, data2=sext(imm), mem_write=1, dest=0.
  - 000100 beq: alu_op=01, data2=rt_data, branch=1, dest=0.
  - 001000 addi: alu_op=00, data2=sext(imm), dest=rt, reg_write=1.
  - any other opcode: accepted and dropped. No valid entry is produced, `illegal` pulses the next cycle, and the register keeps its prior contents and `out_valid` state unless a consume empties it.
- sext(imm) = {{16{imm[15]}}, imm}. data1 is always rs_data.
- Control bits not listed for an opcode are 0.
- Handshake: `in_ready = !out_valid | out_ready`. Accept = in_valid & in_ready & !flush. Consume = out_valid & out_ready.
- Register next state:
  - flush → out_valid=0, all control bits 0.
  - else accept of a legal opcode → load the decoded fields, out_valid=1.
  - else consume → out_valid=0.
  - else hold every output stable.
- `issue_count` increments by 1 on each consume that is not in a flush cycle, and wraps modulo 2^CNT_W.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible with `out_valid=1` after edge N.
- Full throughput: accept and consume in the same cycle replaces the entry with no bubble.
- Backpressure: while out_valid=1 and out_ready=0, `in_ready`=0 and all outputs hold bit-stable.
- Flush and consume in the same cycle: the flush wins. The entry is discarded and not counted.
- Flush and in_valid in the same cycle: the incoming instruction is dropped.
- `illegal` is asserted for exactly one cycle after the accepting edge. It is never asserted during flush.
- Reset (synchronous, with priority over everything, including mid-stall):
  - out_valid=0, illegal=0, issue_count=0.
  - all data and control outputs 0.
  - therefore in_ready=1 in the first cycle after reset.

## Test plan
- R-type add: instr=0x00851020 (rs=4, rt=5, rd=2, funct=100000), rs_data=2, rt_data=2, out_ready=1 → next cycle out_valid=1, alu_op=10, funct=100000, data1=2, data2=2, dest_reg=2, reg_write=1; issue_count=1 after the consume.
- lw with negative offset: instr=0x8C22FFFC, rs_data=0x100 → alu_op=00, data2=0xFFFFFFFC, dest_reg=2, mem_read=1, reg_write=1.
- beq then sw back-to-back with out_ready=1 → two consecutive out_valid cycles:
  - first: alu_op=01, branch=1.
  - second: alu_op=00, mem_write=1, store_data=rt_data.
  - no bubble between them.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs unchanged. Release → the next instruction loads on the following edge.
- Flush while holding a stalled entry with in_valid=1 → out_valid=0 next cycle, the incoming instruction is dropped, issue_count is unchanged.
- Illegal opcode 0x3F, followed by reset asserted mid-stall:
  - illegal opcode → illegal=1 for one cycle, out_valid stays 0.
  - reset → all outputs 0 and issue_count=0 after the edge.
